// File: rtl/ahb3lite_sram_ws.sv
// AHB3-Lite single-port SRAM slave with programmable wait states, zero-wait SEQ beats
// and a two-cycle ERROR response for out-of-range, oversized or misaligned accesses.
module ahb3lite_sram_ws #(
   parameter int HADDR_SIZE  = 32,
   parameter int HDATA_SIZE  = 32,
   parameter int MEM_DEPTH   = 256,
   parameter int WAIT_STATES = 0,
   parameter int FAST_SEQ    = 1
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic                  HSEL,
   input  logic [HADDR_SIZE-1:0] HADDR,
   input  logic [HDATA_SIZE-1:0] HWDATA,
   output logic [HDATA_SIZE-1:0] HRDATA,
   input  logic                  HWRITE,
   input  logic [2:0]            HSIZE,
   input  logic [2:0]            HBURST,
   input  logic [3:0]            HPROT,
   input  logic [1:0]            HTRANS,
   input  logic                  HREADY,
   output logic                  HREADYOUT,
   output logic                  HRESP
);

   localparam int NB = HDATA_SIZE / 8;
   localparam int OB = $clog2(NB);
   localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int IW = HADDR_SIZE - OB;
   localparam logic [2:0] MAX_SIZE = 3'(OB);

   typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

   state_t                state;
   logic [2:0]            wait_cnt;
   logic [AW-1:0]         idx_q;
   logic [NB-1:0]         be_q;
   logic                  write_q;
   logic [HDATA_SIZE-1:0] mem [MEM_DEPTH];

   logic [IW-1:0]         idx_full;
   logic [AW-1:0]         addr_idx;
   logic [AW-1:0]         rd_idx;
   logic [NB-1:0]         be_addr;
   logic                  sample;
   logic                  addr_err;
   logic [2:0]            ws_sel;
   logic                  commit;
   logic [HDATA_SIZE-1:0] rd_word;
   logic                  unused_ok;

   assign unused_ok = ^{HBURST, HPROT};

   assign idx_full = HADDR[HADDR_SIZE-1:OB];
   assign addr_idx = idx_full[AW-1:0];
   assign sample   = HSEL && HREADY && HTRANS[1];
   assign addr_err = (64'(idx_full) >= 64'(MEM_DEPTH)) || (HSIZE > MAX_SIZE) ||
                     (|(HADDR[OB-1:0] & OB'((32'd1 << HSIZE) - 32'd1)));
   assign be_addr  = NB'(((32'd1 << (32'd1 << HSIZE)) - 32'd1) << HADDR[OB-1:0]);
   assign ws_sel   = (HTRANS == 2'b11 && FAST_SEQ != 0) ? 3'd0 : 3'(WAIT_STATES);
   assign commit   = (state == ST_DATA) && write_q && HREADY;
   assign rd_idx   = (state == ST_WAIT) ? idx_q : addr_idx;

   // A read sampled while a write to the same word completes sees the merged word.
   always_comb begin
      // NOTE: rd_word gets its full default before any conditional update, so no latch is inferred.
      rd_word = mem[rd_idx];
      if (commit && rd_idx == idx_q) begin
         for (int i = 0; i < NB; i++) begin
            if (be_q[i]) rd_word[8*i +: 8] = HWDATA[8*i +: 8];
         end
      end
   end

   // NOTE: the storage array is deliberately left out of reset; only the write is gated by it.
   always_ff @(posedge HCLK) begin
      if (commit && !HRESET) begin
         for (int i = 0; i < NB; i++) begin
            if (be_q[i]) mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
         end
      end
   end

   // NOTE: every register here uses <= so all state updates see pre-edge values.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state     <= ST_IDLE;
         wait_cnt  <= 3'd0;
         HREADYOUT <= 1'b1;
         HRESP     <= 1'b0;
         HRDATA    <= '0;
         idx_q     <= '0;
         be_q      <= '0;
         write_q   <= 1'b0;
      end else begin
         case (state)
            ST_WAIT: begin
               if (wait_cnt == 3'd0) begin
                  state     <= ST_DATA;
                  HREADYOUT <= 1'b1;
                  if (!write_q) HRDATA <= rd_word;
               end else begin
                  wait_cnt <= wait_cnt - 3'd1;
               end
            end
            ST_ERR1: begin
               state     <= ST_ERR2;
               HREADYOUT <= 1'b1;
            end
            default: begin
               // IDLE, DATA and ERR2 all accept the next pipelined address phase.
               if (HREADY) begin
                  if (sample) begin
                     idx_q   <= addr_idx;
                     be_q    <= be_addr;
                     write_q <= HWRITE && !addr_err;
                     if (addr_err) begin
                        state     <= ST_ERR1;
                        HREADYOUT <= 1'b0;
                        HRESP     <= 1'b1;
                     end else if (ws_sel == 3'd0) begin
                        state     <= ST_DATA;
                        HREADYOUT <= 1'b1;
                        HRESP     <= 1'b0;
                        if (!HWRITE) HRDATA <= rd_word;
                     end else begin
                        state     <= ST_WAIT;
                        wait_cnt  <= ws_sel - 3'd1;
                        HREADYOUT <= 1'b0;
                        HRESP     <= 1'b0;
                     end
                  end else begin
                     state     <= ST_IDLE;
                     HREADYOUT <= 1'b1;
                     HRESP     <= 1'b0;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ahb3lite_sram_ws.sv
// Bench for ahb3lite_sram_ws: three instances (0/3/2 wait states) share one bus and are
// checked transfer by transfer against a byte-array memory model and timing rules.
`timescale 1ns/1ps
module tb_ahb3lite_sram_ws;

   localparam int DEPTH = 256;
   localparam int NI    = 3;
   localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NSEQ = 2'd2, T_SEQ = 2'd3;

   typedef struct {
      logic        sel;
      logic [1:0]  trans;
      logic        write;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } xfer_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        hsel_bus;
   logic [31:0] haddr, hwdata;
   logic        hwrite;
   logic [2:0]  hsize, hburst;
   logic [3:0]  hprot;
   logic [1:0]  htrans;
   logic        force_nrdy;
   logic [1:0]  sel_i;

   logic [NI-1:0] hsel_k, hro, hrs;
   logic [31:0]   hrd [NI];
   logic          bus_ready, bus_resp;
   logic [31:0]   bus_rdata;

   assign hsel_k    = hsel_bus ? (NI'(1) << sel_i) : '0;
   assign bus_ready = force_nrdy ? 1'b0 : hro[sel_i];
   assign bus_resp  = hrs[sel_i];
   assign bus_rdata = hrd[sel_i];

   always #5 clk = ~clk;

   ahb3lite_sram_ws #(.MEM_DEPTH(DEPTH), .WAIT_STATES(0), .FAST_SEQ(1)) u_ws0 (
      .HCLK(clk), .HRESET(rst), .HSEL(hsel_k[0]), .HADDR(haddr), .HWDATA(hwdata),
      .HRDATA(hrd[0]), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
      .HTRANS(htrans), .HREADY(bus_ready), .HREADYOUT(hro[0]), .HRESP(hrs[0]));
   ahb3lite_sram_ws #(.MEM_DEPTH(DEPTH), .WAIT_STATES(3), .FAST_SEQ(1)) u_ws3 (
      .HCLK(clk), .HRESET(rst), .HSEL(hsel_k[1]), .HADDR(haddr), .HWDATA(hwdata),
      .HRDATA(hrd[1]), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
      .HTRANS(htrans), .HREADY(bus_ready), .HREADYOUT(hro[1]), .HRESP(hrs[1]));
   ahb3lite_sram_ws #(.MEM_DEPTH(DEPTH), .WAIT_STATES(2), .FAST_SEQ(0)) u_ws2 (
      .HCLK(clk), .HRESET(rst), .HSEL(hsel_k[2]), .HADDR(haddr), .HWDATA(hwdata),
      .HRDATA(hrd[2]), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
      .HTRANS(htrans), .HREADY(bus_ready), .HREADYOUT(hro[2]), .HRESP(hrs[2]));

   int          checks = 0;
   int          errors = 0;
   string       phase = "init";
   xfer_t       q[$];
   xfer_t       idle_x = '{sel: 1'b0, trans: T_IDLE, write: 1'b0, size: 3'd0, addr: 32'd0, wdata: 32'd0};
   logic [7:0]  mem_m [NI][DEPTH*4];
   logic [31:0] last_rd;
   int          xfer_cycles;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s/%s got=%h exp=%h", phase, tag, got, exp);
      end
   endtask

   function automatic int ws_of(input logic [1:0] k);
      return (k == 2'd0) ? 0 : (k == 2'd1) ? 3 : 2;
   endfunction

   function automatic bit fast_of(input logic [1:0] k);
      return k != 2'd2;
   endfunction

   function automatic bit is_active(input xfer_t x);
      return x.sel && (x.trans == T_NSEQ || x.trans == T_SEQ);
   endfunction

   function automatic bit is_err(input xfer_t x);
      return is_active(x) && ((x.addr / 4) >= DEPTH || x.size > 3'd2 ||
                              (x.addr % (32'd1 << x.size)) != 0);
   endfunction

   function automatic int exp_wait(input xfer_t x);
      if (!is_active(x)) return 0;
      if (is_err(x)) return 1;
      if (x.trans == T_SEQ && fast_of(sel_i)) return 0;
      return ws_of(sel_i);
   endfunction

   function automatic logic [31:0] model_word(input logic [31:0] addr);
      int a = int'(addr & ~32'd3);
      return {mem_m[sel_i][a+3], mem_m[sel_i][a+2], mem_m[sel_i][a+1], mem_m[sel_i][a]};
   endfunction

   function automatic xfer_t mk(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                                input logic [31:0] ad, input logic [31:0] wd);
      xfer_t x = '{sel: 1'b1, trans: tr, write: wr, size: sz, addr: ad, wdata: wd};
      return x;
   endfunction

   task automatic drive(input xfer_t x);
      hsel_bus = x.sel;
      htrans   = x.trans;
      hwrite   = x.write;
      hsize    = x.size;
      haddr    = x.addr;
      hburst   = 3'($urandom_range(0, 7));
      hprot    = 4'($urandom_range(0, 15));
   endtask

   task automatic complete(input xfer_t x, input int low, input logic rlow);
      logic [31:0] exp;
      int          off;
      check("wait", low, exp_wait(x));
      check("resp", 32'({rlow, bus_resp}), is_err(x) ? 32'd3 : 32'd0);
      if (is_active(x) && !is_err(x)) begin
         xfer_cycles += low + 1;
         off = int'(x.addr % 4);
         if (x.write) begin
            for (int b = 0; b < (1 << x.size); b++)
               mem_m[sel_i][int'(x.addr) + b] = x.wdata[8*(off + b) +: 8];
         end else begin
            exp = model_word(x.addr);
            check("rdata", bus_rdata, exp);
            last_rd = bus_rdata;
         end
      end
   endtask

   // Pipelined master: drives the next address phase while the previous data phase runs.
   task automatic run();
      xfer_t cur, nxt;
      bit    cur_v  = 1'b0;
      int    i      = 0;
      int    low    = 0;
      logic  rlow   = 1'b0;
      logic  rdy;
      int    budget = 20 * q.size() + 20;
      cur = idle_x;
      while (i < q.size() || cur_v) begin
         if (i < q.size()) nxt = q[i];
         else nxt = idle_x;
         drive(nxt);
         hwdata = (cur_v && cur.write) ? cur.wdata : $urandom();
         @(negedge clk);
         rdy = bus_ready;
         if (cur_v) begin
            if (!rdy) begin
               low++;
               rlow |= bus_resp;
            end else begin
               complete(cur, low, rlow);
            end
         end
         @(posedge clk);
         #1;
         if (rdy) begin
            cur_v = (i < q.size());
            if (cur_v) begin
               cur = q[i];
               i++;
            end
            low  = 0;
            rlow = 1'b0;
         end
         budget--;
         if (budget == 0) begin
            check("timeout", 32'd1, 32'd0);
            break;
         end
      end
      drive(idle_x);
      q.delete();
   endtask

   function automatic xfer_t rand_xfer();
      xfer_t x;
      int    r, word, off;
      x.sel   = ($urandom_range(0, 99) >= 8);
      r       = $urandom_range(0, 9);
      x.trans = (r < 5) ? T_NSEQ : (r < 8) ? T_SEQ : (r == 8) ? T_IDLE : T_BUSY;
      x.write = 1'($urandom_range(0, 1));
      x.size  = ($urandom_range(0, 15) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      word    = ($urandom_range(0, 19) == 0) ? DEPTH + $urandom_range(0, 7) : $urandom_range(0, 31);
      if ($urandom_range(0, 9) == 0) off = $urandom_range(0, 3);
      else if (x.size > 3'd2) off = 0;
      else off = ($urandom_range(0, 3) >> x.size) << x.size;
      x.addr  = 32'(word * 4 + off);
      x.wdata = $urandom();
      return x;
   endfunction

   initial begin
      rst = 1'b1;
      force_nrdy = 1'b0;
      sel_i = 2'd0;
      drive(idle_x);
      hwdata = 32'd0;
      last_rd = 32'd0;
      xfer_cycles = 0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      phase = "reset";
      for (int k = 0; k < NI; k++) begin
         check("hreadyout", 32'(hro[k]), 32'd1);
         check("hresp", 32'(hrs[k]), 32'd0);
         check("hrdata", hrd[k], 32'd0);
      end

      phase = "init";
      for (int k = 0; k < NI; k++) begin
         sel_i = 2'(k);
         for (int w = 0; w < 32; w++) q.push_back(mk(T_NSEQ, 1'b1, 3'd2, 32'(w * 4), $urandom()));
         run();
      end

      phase = "word_rw";
      sel_i = 2'd0;
      q.push_back(mk(T_NSEQ, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF));
      q.push_back(mk(T_NSEQ, 1'b0, 3'd2, 32'h10, 32'h0));
      run();
      check("t1_data", last_rd, 32'hDEADBEEF);

      phase = "bytes";
      q.push_back(mk(T_NSEQ, 1'b1, 3'd0, 32'h20, 32'h00000011));
      q.push_back(mk(T_NSEQ, 1'b1, 3'd0, 32'h21, 32'h00002200));
      q.push_back(mk(T_NSEQ, 1'b1, 3'd0, 32'h22, 32'h00330000));
      q.push_back(mk(T_NSEQ, 1'b1, 3'd0, 32'h23, 32'h44000000));
      q.push_back(mk(T_NSEQ, 1'b0, 3'd2, 32'h20, 32'h0));
      run();
      check("bytes_word", last_rd, 32'h44332211);
      q.push_back(mk(T_NSEQ, 1'b1, 3'd1, 32'h22, 32'hABCD0000));
      q.push_back(mk(T_NSEQ, 1'b0, 3'd2, 32'h20, 32'h0));
      run();
      check("half_word", last_rd, 32'hABCD2211);

      phase = "bypass";
      q.push_back(mk(T_NSEQ, 1'b1, 3'd2, 32'h40, 32'h12345678));
      q.push_back(mk(T_NSEQ, 1'b0, 3'd2, 32'h40, 32'h0));
      run();
      check("raw_data", last_rd, 32'h12345678);

      phase = "hready_hold";
      force_nrdy = 1'b1;
      drive(mk(T_NSEQ, 1'b0, 3'd2, 32'h10, 32'h0));
      repeat (2) @(posedge clk);
      #1;
      check("hold_rdata", hrd[0], 32'h12345678);
      check("hold_ready", 32'(hro[0]), 32'd1);
      drive(idle_x);
      force_nrdy = 1'b0;
      @(posedge clk);
      #1;
      check("hold_after", hrd[0], 32'h12345678);

      phase = "errors";
      q.push_back(mk(T_NSEQ, 1'b1, 3'd2, 32'h00, 32'hAAAA5555));
      q.push_back(mk(T_NSEQ, 1'b1, 3'd2, 32'h02, 32'h11111111));
      q.push_back(mk(T_NSEQ, 1'b1, 3'd3, 32'h00, 32'h22222222));
      q.push_back(mk(T_NSEQ, 1'b0, 3'd2, 32'(DEPTH * 4), 32'h0));
      q.push_back(mk(T_IDLE, 1'b0, 3'd0, 32'h0, 32'h0));
      q.push_back(mk(T_NSEQ, 1'b1, 3'd2, 32'(DEPTH * 4), 32'h33333333));
      q.push_back(mk(T_NSEQ, 1'b0, 3'd2, 32'h00, 32'h0));
      run();
      check("err_mem_kept", last_rd, 32'hAAAA5555);

      phase = "incr4";
      for (int k = 0; k < NI; k++) begin
         sel_i = 2'(k);
         xfer_cycles = 0;
         q.push_back(mk(T_NSEQ, 1'b0, 3'd2, 32'h00, 32'h0));
         q.push_back(mk(T_SEQ, 1'b0, 3'd2, 32'h04, 32'h0));
         q.push_back(mk(T_SEQ, 1'b0, 3'd2, 32'h08, 32'h0));
         q.push_back(mk(T_SEQ, 1'b0, 3'd2, 32'h0C, 32'h0));
         run();
         check("incr4_cycles", xfer_cycles, (k == 0) ? 32'd4 : (k == 1) ? 32'd7 : 32'd12);
      end

      phase = "reset_mid";
      sel_i = 2'd1;
      q.push_back(mk(T_NSEQ, 1'b1, 3'd2, 32'h50, 32'h0BADF00D));
      run();
      drive(mk(T_NSEQ, 1'b1, 3'd2, 32'h50, 32'h0));
      @(posedge clk);
      #1;
      drive(idle_x);
      hwdata = 32'hCAFEF00D;
      @(negedge clk);
      check("in_wait", 32'(bus_ready), 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_ready", 32'(hro[1]), 32'd1);
      check("rst_resp", 32'(hrs[1]), 32'd0);
      check("rst_rdata", hrd[1], 32'd0);
      q.push_back(mk(T_NSEQ, 1'b0, 3'd2, 32'h50, 32'h0));
      run();
      check("old_value", last_rd, 32'h0BADF00D);

      phase = "random";
      for (int k = 0; k < NI; k++) begin
         sel_i = 2'(k);
         for (int n = 0; n < 80; n++) q.push_back(rand_xfer());
         run();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ahb3lite_sram_ws.md
# ahb3lite_sram_ws

AHB3-Lite SRAM slave, next generation of the team's single-port SRAM slave. Adds configurable data width, programmable wait states with optional zero-wait sequential burst beats, and a two-cycle ERROR response for out-of-range, oversized or misaligned accesses. Sits on the AHB3-Lite bus behind the decoder (HSEL) and is driven by the existing AHB interface/agent bench.

## Interface
- HADDR_SIZE, 32, address bus width
- HDATA_SIZE, 32, data bus width; legal values 32 or 64
- MEM_DEPTH, 256, memory depth in HDATA_SIZE-wide words
- WAIT_STATES, 0, wait cycles inserted on NONSEQ data phases; range 0..7
- FAST_SEQ, 1, when 1, SEQ beats complete with zero wait states regardless of WAIT_STATES

Ports:
- HCLK  in  1  bus clock; all logic on rising edge
- HRESET  in  1  synchronous, active-high reset
- HSEL  in  1  slave select
- HADDR  in  HADDR_SIZE  transfer address (byte address)
- HWDATA  in  HDATA_SIZE  write data, data phase
- HRDATA  out  HDATA_SIZE  read data, valid when HREADYOUT=1 and HRESP=0
- HWRITE  in  1  1=write, 0=read
- HSIZE  in  3  transfer size (0=byte, 1=half, 2=word, 3=dword)
- HBURST  in  3  burst type; accepted, no behavioural effect
- HPROT  in  4  protection; accepted, ignored
- HTRANS  in  2  0=IDLE, 1=BUSY, 2=NONSEQ, 3=SEQ
- HREADY  in  1  bus-wide ready
- HREADYOUT  out  1  this slave's ready
- HRESP  out  1  0=OKAY, 1=ERROR

## Operation
- Address phase sampled only when HSEL=1, HREADY=1 and HTRANS is NONSEQ or SEQ. Captured fields: word index, byte offset, HSIZE, HWRITE, HTRANS.
- IDLE and BUSY transfers, and any cycle with HSEL=0, produce a zero-wait OKAY response.
- Error checks at address sampling:
  - word index ≥ MEM_DEPTH
  - HSIZE > log2(HDATA_SIZE/8)
  - address not aligned to HSIZE
- Any error gives a two-cycle response (ERR1: HREADYOUT=0/HRESP=1; ERR2: HREADYOUT=1/HRESP=1). No memory update.
- State machine:
  - IDLE → WAIT when a valid transfer is sampled and the wait count > 0.
  - IDLE → DATA when a valid transfer is sampled and the wait count = 0.
  - IDLE → ERR1 when an erroneous transfer is sampled.
  - WAIT counts down to DATA.
  - ERR1 → ERR2.
  - DATA and ERR2 return to IDLE, or accept the next pipelined address (back-to-back).
- Wait count is WAIT_STATES for NONSEQ. For SEQ it is 0 if FAST_SEQ=1, otherwise WAIT_STATES.
- Writes: byte enables come from HSIZE and the byte offset. HWDATA lanes are committed to memory at the HCLK edge ending DATA (HREADYOUT=1). Unselected lanes are unchanged.
- Reads: HRDATA is a registered full word. Unselected lanes still carry memory contents.
- Read-after-write: a read whose address phase coincides with the data phase of a write to the same word returns the merged (new) data via bypass.
- Memory contents are not cleared by reset.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, state=IDLE, wait counter=0.
- Reset mid-transfer: the transfer is aborted and any pending write is discarded. The outputs take reset values on the next edge.
- NONSEQ data phase lasts WAIT_STATES+1 cycles; HREADYOUT is low for exactly WAIT_STATES cycles.
- With FAST_SEQ=1, a SEQ beat completes in 1 cycle, so an INCR4 with WAIT_STATES=2 takes 3+1+1+1 = 6 data cycles.
- HREADY=0 from another slave: no address is sampled, and state, outputs and counter hold.
- ERROR on the first ERR1 cycle: if the master drives IDLE during ERR2, the next address is not sampled until ERR2 completes.
- Throughput with WAIT_STATES=0 is one transfer per cycle with no bubbles.

## Test plan
- Reset, then word write 0xDEADBEEF to 0x10 and word read from 0x10 (WAIT_STATES=0) → HRDATA=0xDEADBEEF on the read data phase, HRESP=0, HREADYOUT never low.
- Byte writes 0x11/0x22/0x33/0x44 to 0x20..0x23, then word read 0x20 → 0x44332211. Halfword 0xABCD to 0x22, then read → 0xABCD2211.
- WAIT_STATES=3: NONSEQ read → HREADYOUT low for 3 cycles, then high with data. INCR4 with FAST_SEQ=1 → 4+1+1+1 data cycles.
- Read of address MEM_DEPTH*4, word access at 0x02, and HSIZE=3 with HDATA_SIZE=32 → each gives ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (1, 1), and memory is unchanged.
- Back-to-back write 0x12345678 to 0x40 followed immediately by a read of 0x40 → the read returns 0x12345678 via bypass.
- HRESET asserted during WAIT of a write of 0xCAFEF00D → next cycle HREADYOUT=1, HRESP=0; a later read of that address returns the old value.
